// File: rtl/main_memory_responder.sv
// Fixed-latency main-memory model: in-order request queue, data = addr ^ DATA_SEED.
// Optional MM_JITTER_EN adds 0-3 LFSR-driven extra cycles per accepted request.
module main_memory_responder #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 16,
  parameter int          NUM_OPS     = 32,
  parameter int          LATENCY     = 4,
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] DATA_SEED   = 32'hA5A5_0000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            mm_req,
  input  logic [$clog2(NUM_OPS)-1:0]       mm_req_op,
  input  logic                             mm_req_valid,
  output logic [DATA_WIDTH-1:0]            mm_ret_data,
  output logic [$clog2(NUM_OPS)-1:0]       mm_ret_op,
  output logic                             mm_ret_valid,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] pending,
  output logic                             overflow
);

  localparam int OW   = $clog2(NUM_OPS);
  localparam int PW   = $clog2(QUEUE_DEPTH);
  localparam int CNTW = $clog2(QUEUE_DEPTH+1);
  localparam int CDW  = $clog2(LATENCY+4);
  localparam logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(DATA_SEED);

  logic [ADDR_WIDTH-1:0]  addr_q [QUEUE_DEPTH];
  logic [OW-1:0]          op_q   [QUEUE_DEPTH];
  logic [CDW-1:0]         cnt_q  [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] vld_q;

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  ret_v_q, ret_v_d;
  logic [OW-1:0]         ret_op_q, ret_op_d;
  logic [DATA_WIDTH-1:0] ret_data_q, ret_data_d;

  logic           pop, push, full;
  logic [CDW-1:0] init_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

`ifdef MM_JITTER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr_q <= 16'hACE1;
    else if (push)
      lfsr_q <= {lfsr_q[14:0],
                 lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign init_cnt = CDW'(LATENCY-1) + CDW'(lfsr_q[1:0]);
`else
  assign init_cnt = CDW'(LATENCY-1);
`endif

  always_comb begin
    full = (count_q == CNTW'(QUEUE_DEPTH));
    pop  = vld_q[head_q] && (cnt_q[head_q] == '0);
    // A pop frees the head slot on the same edge, so a full queue still accepts
    push = mm_req_valid && (!full || pop);

    head_d     = pop  ? ptr_inc(head_q) : head_q;
    tail_d     = push ? ptr_inc(tail_q) : tail_q;
    count_d    = count_q + CNTW'(push) - CNTW'(pop);
    ovf_d      = ovf_q | (mm_req_valid & ~push);
    ret_v_d    = pop;
    ret_op_d   = ret_op_q;
    ret_data_d = ret_data_q;
    if (pop) begin
      ret_op_d   = op_q[head_q];
      ret_data_d = DATA_WIDTH'(addr_q[head_q]) ^ SEED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ret_v_q    <= 1'b0;
      ret_op_q   <= '0;
      ret_data_q <= '0;
      vld_q      <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        addr_q[i] <= '0;
        op_q[i]   <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      ret_v_q    <= ret_v_d;
      ret_op_q   <= ret_op_d;
      ret_data_q <= ret_data_d;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (push && tail_q == PW'(i)) begin
          addr_q[i] <= mm_req;
          op_q[i]   <= mm_req_op;
          cnt_q[i]  <= init_cnt;
          vld_q[i]  <= 1'b1;
        end else begin
          if (vld_q[i] && cnt_q[i] != '0)
            cnt_q[i] <= cnt_q[i] - 1'b1;
          if (pop && head_q == PW'(i))
            vld_q[i] <= 1'b0;
        end
      end
    end
  end

  assign mm_ret_valid = ret_v_q;
  assign mm_ret_op    = ret_op_q;
  assign mm_ret_data  = ret_data_q;
  assign pending      = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized bench for main_memory_responder against a due-time queue model.
// Non-power-of-two depth smaller than the latency exercises drop and full pop+push.
module tb_main_memory_responder;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int NOPS = 32;
  localparam int L    = 4;
  localparam int QD   = 3;
  localparam int OW   = $clog2(NOPS);
  localparam int PCW  = $clog2(QD+1);
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  mm_req;
  logic [OW-1:0]  mm_req_op;
  logic           mm_req_valid;
  logic [DW-1:0]  mm_ret_data;
  logic [OW-1:0]  mm_ret_op;
  logic           mm_ret_valid;
  logic [PCW-1:0] pending;
  logic           overflow;

  main_memory_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_OPS(NOPS),
    .LATENCY(L), .QUEUE_DEPTH(QD), .DATA_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset),
    .mm_req(mm_req), .mm_req_op(mm_req_op), .mm_req_valid(mm_req_valid),
    .mm_ret_data(mm_ret_data), .mm_ret_op(mm_ret_op),
    .mm_ret_valid(mm_ret_valid), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [OW-1:0] op;
    int            due;
  } ent_t;

  ent_t          mq[$];
  int            edge_n = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  logic [15:0]   m_lfsr = 16'hACE1;
  logic          e_v = 1'b0;
  logic [OW-1:0] e_op = '0;
  logic [DW-1:0] e_data = '0;
  logic          e_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    mq.delete();
    e_v = 1'b0; e_op = '0; e_data = '0; e_ovf = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  // Entry accepted at edge e is due for return at edge e+L(+jitter); in order
  task automatic model_edge();
    ent_t h;
    int   extra;
    edge_n++;
    e_v = 1'b0;
    if (mq.size() > 0 && mq[0].due <= edge_n) begin
      h      = mq.pop_front();
      e_v    = 1'b1;
      e_op   = h.op;
      e_data = {16'h0, h.a} ^ SEED;
    end
    if (mm_req_valid) begin
      if (mq.size() < QD) begin
        extra = 0;
`ifdef MM_JITTER_EN
        extra  = int'(m_lfsr[1:0]);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        mq.push_back('{a: mm_req, op: mm_req_op, due: edge_n + L + extra});
      end else begin
        e_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("ret_valid", 64'(mm_ret_valid), 64'(e_v));
    check("ret_op",    64'(mm_ret_op),    64'(e_op));
    check("ret_data",  64'(mm_ret_data),  64'(e_data));
    check("pending",   64'(pending),      64'(mq.size()));
    check("overflow",  64'(overflow),     64'(e_ovf));
  endtask

  task automatic step(input logic v, input logic [AW-1:0] a,
                      input logic [OW-1:0] op);
    mm_req_valid = v;
    mm_req       = a;
    mm_req_op    = op;
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, AW'($urandom), OW'($urandom));
  endtask

  int thr;

  initial begin
    reset = 1'b1;
    mm_req_valid = 1'b0;
    mm_req = '0;
    mm_req_op = '0;
    #1;
    compare_all();
    idle(2);
    reset = 1'b0;
    idle(10);

    // single request, fixed latency and data pattern
    step(1'b1, 16'h1234, 5'd5);
    idle(8);

    // back-to-back burst: drops once depth is exceeded, full pop+push reuse
    for (int i = 0; i < 8; i++)
      step(1'b1, AW'(16'h0100 + i), OW'(i));
    idle(10);
    for (int i = 0; i < 12; i++)
      step(1'b1, AW'(16'h0200 + i), OW'(i + 8));
    idle(10);

    // asynchronous reset mid-cycle with requests in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, AW'(16'h0300 + i), OW'(i + 20));
    mm_req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    compare_all();
    idle(2);
    reset = 1'b0;
    idle(6);
    step(1'b1, 16'hBEEF, 5'd17);
    idle(8);

    // random traffic with varying request density
    for (int blk = 0; blk < 8; blk++) begin
      thr = $urandom_range(10, 100);
      for (int i = 0; i < 50; i++)
        step(($urandom_range(0, 99) < thr), AW'($urandom), OW'($urandom));
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Main-memory side of the cache/MSHR memory interface: accepts miss requests (address + op tag), returns data with a fixed, parameterised latency.
- Drives the mm_ret_* inputs of non_blocking_cache and consumes its mm_req* outputs.
- Serves as the synthesisable memory model for system simulation and FPGA bring-up.
- Internal in-order request queue with per-entry latency countdown; returned data is a deterministic function of the address.

Parameters:
- DATA_WIDTH, 32, returned data width.
- ADDR_WIDTH, 16, request address width.
- NUM_OPS, 32, op-tag space; tag width is $clog2(NUM_OPS).
- LATENCY, 4, minimum cycles from request to return, must be >= 1.
- QUEUE_DEPTH, 8, outstanding-request capacity, must be >= 2.
- DATA_SEED, 32'hA5A5_0000, XOR pattern applied to the address to form the data.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mm_req  in  ADDR_WIDTH  requested address.
- mm_req_op  in  $clog2(NUM_OPS)  op tag of the request.
- mm_req_valid  in  1  request present this cycle. There is no ready signal; the block must accept the request or drop it.
- mm_ret_data  out  DATA_WIDTH  returned data.
- mm_ret_op  out  $clog2(NUM_OPS)  op tag of the returned request.
- mm_ret_valid  out  1  single-cycle return strobe.
- pending  out  $clog2(QUEUE_DEPTH+1)  number of queued entries.
- overflow  out  1  sticky flag: a request was dropped.

Behaviour:
- Reset (async, active-high): queue emptied; pointers and counts cleared; LFSR reloaded (if enabled). All outputs forced to 0. In-flight requests are discarded and never returned.
- Entry contents: addr, op, countdown (width $clog2(LATENCY+4)).
- Enqueue: on each edge with mm_req_valid=1 and a free slot, write the entry at the tail with countdown = LATENCY-1.
- Countdown update, every edge: every valid entry with countdown>0 decrements, except an entry being written on that edge.
- Dequeue: if the head is valid with countdown==0, pop it at the edge and register the outputs:
  - mm_ret_valid=1
  - mm_ret_op=head.op
  - mm_ret_data = zero-extended head.addr XOR DATA_SEED (truncated or extended to DATA_WIDTH)
- Maximum one pop per edge. When nothing pops, mm_ret_valid=0 and data/op hold their last values.
- Latency: a request presented in cycle c returns with mm_ret_valid high in cycle c+LATENCY+1, provided no earlier entry is blocking the head. Returns are strictly in request order.
- Full boundary:
  - Enqueue and dequeue on the same edge while full: the request is accepted (the popped slot is reused) and no overflow is flagged.
  - Request while full with no pop on that edge: the request is dropped and overflow is set. overflow stays set until reset.
- Pointers: wrap modulo QUEUE_DEPTH, with correct handling of non-power-of-two depths. pending = occupancy; it changes by -1, 0 or +1 per edge.
- mm_req and mm_req_op are ignored when mm_req_valid=0.

Optional Feature:
- Macro: MM_JITTER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances on every accepted request.
  - The accepted request's initial countdown becomes LATENCY-1+lfsr[1:0], i.e. 0–3 extra cycles.
  - Ordering stays strictly in order, so a delayed head holds back younger ready entries.
- Undefined: fixed latency exactly as above; no LFSR logic exists.

Test Plan:
1. Single request, addr 16'h1234, op 5, in cycle 10 (defaults) -> cycle 15 shows mm_ret_valid=1, data=32'hA5A5_1234, op=5. mm_ret_valid=0 in cycles 11–14 and 16.
2. Eight back-to-back requests, addr 16'h0100+i, op i, in cycles 0–7 -> returns in cycles 5–12 on consecutive cycles, ops 0..7 in order. pending peaks at 4; overflow=0.
3. QUEUE_DEPTH=2, LATENCY=4, requests in cycles 0,1,2 with ops 1,2,3 -> overflow=1 from cycle 3 onward. Only ops 1 and 2 return (cycles 5, 6); op 3 never returns.
4. QUEUE_DEPTH=4, LATENCY=4, continuous requests in cycles 0–11 -> edge 4 performs a simultaneous pop and push while full. All 12 requests return in cycles 5–16; overflow=0; pending never exceeds 4.
5. Reset asserted asynchronously mid-cycle 3 after requests in cycles 0–2 (held for 2 cycles) -> outputs go to 0 immediately and pending=0. No returns follow; a new request after reset returns LATENCY+1 cycles later.
6. MM_JITTER_EN defined, 16 back-to-back requests -> returns arrive in request order. Each return occurs between LATENCY+1 and LATENCY+4 cycles after its request, or later when blocked by the head. All data values are correct.
